// File: rtl/exm_pipe_stage_if.sv
// rtl/exm_pipe_stage_if.sv - memory port bundle between exm_pipe_stage and its data memory
interface exm_pipe_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
);
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              i_mem_ack;
    logic [DATA_W-1:0] i_mem_rdata;

    modport master (
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_ack, i_mem_rdata
    );

    modport slave (
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_ack, i_mem_rdata
    );
endinterface

// File: rtl/exm_pipe_stage.sv
// rtl/exm_pipe_stage.sv - execute/memory stage with ALU, branches and a descending stack
// Optional stack overflow/underflow guard enabled by defining EXM_STACK_GUARD_EN.
module exm_pipe_stage #(
    parameter int          DATA_W  = 16,
    parameter int          ADDR_W  = 11,
    parameter int unsigned SP_INIT = 2**ADDR_W-1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_busy,
    input  logic [3:0]          i_op,
    input  logic [2:0]          i_alu_function,
    input  logic [DATA_W-1:0]   i_data1,
    input  logic [DATA_W-1:0]   i_data2,
    input  logic [2*DATA_W-1:0] i_pc,
    exm_pipe_stage_if.master    mem,
    output logic                o_valid,
    output logic [DATA_W-1:0]   o_result,
    output logic                o_branch_decision,
    output logic [2*DATA_W-1:0] o_pc_new,
    output logic [2:0]          o_flags,
    output logic [ADDR_W-1:0]   o_sp,
    output logic                o_fault
);
    localparam logic [3:0] OP_ALU = 4'd1, OP_MOV = 4'd2, OP_LOAD = 4'd3, OP_STORE = 4'd4,
                           OP_PUSH = 4'd5, OP_POP = 4'd6, OP_CALL = 4'd7, OP_RET = 4'd8,
                           OP_JZ = 4'd9, OP_JN = 4'd10, OP_JC = 4'd11, OP_JMP = 4'd12,
                           OP_SETC = 4'd13, OP_CLRC = 4'd14;
    localparam logic [ADDR_W-1:0] SP_RST = ADDR_W'(SP_INIT);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;

    state_t              state, state_nxt;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   d1_q, lo_q;
    logic [ADDR_W-1:0]   addr_q, sp;
    logic [2*DATA_W-1:0] pc_q;
    logic [2:0]          flags;
    logic [DATA_W:0]     alu_ext;
    logic                alu_c_upd, accept, mem_op, two_phase, final_ack, guard_fault;

    assign accept    = i_valid && (state == IDLE);
    assign mem_op    = (i_op >= OP_LOAD) && (i_op <= OP_RET);
    assign two_phase = (op_q == OP_CALL) || (op_q == OP_RET);
    assign final_ack = mem.i_mem_ack && ((state == ACC1) || (state == ACC0 && !two_phase));
    assign o_flags   = flags;
    assign o_sp      = sp;

`ifdef EXM_STACK_GUARD_EN
    logic [ADDR_W:0] sp_ext;
    assign sp_ext = {1'b0, sp};
    always_comb begin
        guard_fault = 1'b0;
        case (i_op)
            OP_PUSH: guard_fault = (sp_ext == '0);
            OP_CALL: guard_fault = (sp_ext < (ADDR_W+1)'(2));
            OP_POP:  guard_fault = (sp_ext + (ADDR_W+1)'(1) > {1'b0, SP_RST});
            OP_RET:  guard_fault = (sp_ext + (ADDR_W+1)'(2) > {1'b0, SP_RST});
            default: guard_fault = 1'b0;
        endcase
    end
`else
    assign guard_fault = 1'b0;
`endif

    // Top bit of alu_ext is carry for add forms and borrow for subtract forms.
    always_comb begin
        alu_ext   = '0;
        alu_c_upd = 1'b0;
        case (i_alu_function)
            3'd0: begin alu_ext = {1'b0, i_data1} + {1'b0, i_data2}; alu_c_upd = 1'b1; end
            3'd1: begin alu_ext = {1'b0, i_data1} - {1'b0, i_data2}; alu_c_upd = 1'b1; end
            3'd2: alu_ext = {1'b0, i_data1 & i_data2};
            3'd3: alu_ext = {1'b0, i_data1 | i_data2};
            3'd4: alu_ext = {1'b0, ~i_data1};
            3'd5: begin alu_ext = {1'b0, i_data1} + (DATA_W+1)'(1); alu_c_upd = 1'b1; end
            3'd6: begin alu_ext = {1'b0, i_data1} - (DATA_W+1)'(1); alu_c_upd = 1'b1; end
            default: alu_ext = {1'b0, i_data1};
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && mem_op && !guard_fault) state_nxt = ACC0;
            ACC0:    if (mem.i_mem_ack) state_nxt = two_phase ? ACC1 : IDLE;
            ACC1:    if (mem.i_mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy          = (state != IDLE);
        mem.o_mem_req   = (state != IDLE);
        mem.o_mem_we    = (op_q == OP_STORE) || (op_q == OP_PUSH) || (op_q == OP_CALL);
        mem.o_mem_wdata = d1_q;
        mem.o_mem_addr  = addr_q;
        case (op_q)
            OP_PUSH: mem.o_mem_addr = sp;
            OP_POP:  mem.o_mem_addr = sp + ADDR_W'(1);
            OP_CALL: begin
                mem.o_mem_addr  = (state == ACC1) ? sp - ADDR_W'(1) : sp;
                mem.o_mem_wdata = (state == ACC1) ? pc_q[DATA_W-1:0] : pc_q[2*DATA_W-1:DATA_W];
            end
            OP_RET:  mem.o_mem_addr = (state == ACC1) ? sp + ADDR_W'(2) : sp + ADDR_W'(1);
            default: mem.o_mem_addr = addr_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            op_q <= '0; d1_q <= '0; addr_q <= '0; pc_q <= '0; lo_q <= '0;
            sp <= SP_RST; flags <= '0;
            o_valid <= 1'b0; o_result <= '0; o_branch_decision <= 1'b0;
            o_pc_new <= '0; o_fault <= 1'b0;
        end else begin
            o_valid           <= 1'b0;
            o_branch_decision <= 1'b0;
            o_fault           <= 1'b0;
            if (accept) begin
                op_q   <= i_op;
                d1_q   <= i_data1;
                addr_q <= i_data2[ADDR_W-1:0];
                pc_q   <= i_pc;
            end
            if (accept && !mem_op) begin
                o_valid <= 1'b1;
                case (i_op)
                    OP_ALU: begin
                        o_result <= alu_ext[DATA_W-1:0];
                        flags    <= {alu_ext[DATA_W-1:0] == '0, alu_ext[DATA_W-1],
                                     alu_c_upd ? alu_ext[DATA_W] : flags[0]};
                    end
                    OP_MOV:  o_result <= i_data2;
                    OP_JZ, OP_JN, OP_JC, OP_JMP: begin
                        if ((i_op == OP_JMP) || (i_op == OP_JZ && flags[2]) ||
                            (i_op == OP_JN && flags[1]) || (i_op == OP_JC && flags[0])) begin
                            o_branch_decision <= 1'b1;
                            o_pc_new          <= {{DATA_W{1'b0}}, i_data1};
                        end
                    end
                    OP_SETC: flags[0] <= 1'b1;
                    OP_CLRC: flags[0] <= 1'b0;
                    default: ;
                endcase
            end
            if (accept && mem_op && guard_fault) begin
                o_valid  <= 1'b1;
                o_fault  <= 1'b1;
                o_result <= '0;
            end
            if (state == ACC0 && mem.i_mem_ack && op_q == OP_RET) lo_q <= mem.i_mem_rdata;
            // SP commits only on the final acknowledge so o_sp never shows half a CALL/RET.
            if (final_ack) begin
                o_valid <= 1'b1;
                case (op_q)
                    OP_LOAD: o_result <= mem.i_mem_rdata;
                    OP_PUSH: sp <= sp - ADDR_W'(1);
                    OP_POP: begin
                        o_result <= mem.i_mem_rdata;
                        sp       <= sp + ADDR_W'(1);
                    end
                    OP_CALL: begin
                        sp                <= sp - ADDR_W'(2);
                        o_branch_decision <= 1'b1;
                        o_pc_new          <= {{DATA_W{1'b0}}, d1_q};
                    end
                    OP_RET: begin
                        sp                <= sp + ADDR_W'(2);
                        o_branch_decision <= 1'b1;
                        o_pc_new          <= {mem.i_mem_rdata, lo_q};
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_exm_pipe_stage.sv
// tb/tb_exm_pipe_stage.sv - scoreboard bench for exm_pipe_stage with a behavioural reference model
`timescale 1ns/1ps
module tb_exm_pipe_stage;
    localparam int DW     = 16;
    localparam int AW     = 11;
    localparam int MEM_N  = 2**AW;
    localparam int SP_TOP = MEM_N - 1;
`ifdef EXM_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct { int result; bit chk_result; bit branch; longint pc_new; int flags; int sp; bit fault; } exp_t;
    typedef struct { logic [AW-1:0] addr; bit we; logic [DW-1:0] wdata; } acc_t;

    logic          clk = 1'b0, rst = 1'b1;
    logic          v_valid = 1'b0;
    logic [3:0]    v_op = '0;
    logic [2:0]    v_fn = '0;
    logic [DW-1:0] v_d1 = '0, v_d2 = '0;
    logic [31:0]   v_pc = '0;
    logic          o_busy, o_valid, o_branch_decision, o_fault;
    logic [DW-1:0] o_result;
    logic [31:0]   o_pc_new;
    logic [2:0]    o_flags;
    logic [AW-1:0] o_sp;
    logic          resp_en = 1'b1, resp_ack = 1'b0, man_ack = 1'b0;
    logic [DW-1:0] resp_rdata = '0;
    int            fixed_delay = -1;

    exp_t exp_q[$];
    acc_t acc_q[$];
    int   ref_mem[MEM_N];
    int   bus_mem[MEM_N];
    int   m_sp;
    bit   mz, mn, mc;
    int   n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    exm_pipe_stage_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();
    assign mem_if.i_mem_ack   = resp_en ? resp_ack : man_ack;
    assign mem_if.i_mem_rdata = resp_rdata;

    exm_pipe_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(v_valid), .o_busy(o_busy),
        .i_op(v_op), .i_alu_function(v_fn), .i_data1(v_d1), .i_data2(v_d2), .i_pc(v_pc),
        .mem(mem_if), .o_valid(o_valid), .o_result(o_result),
        .o_branch_decision(o_branch_decision), .o_pc_new(o_pc_new), .o_flags(o_flags),
        .o_sp(o_sp), .o_fault(o_fault)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_acc(input int addr, input bit we, input int wdata);
        acc_t a;
        a.addr = AW'(addr); a.we = we; a.wdata = DW'(wdata);
        acc_q.push_back(a);
    endtask

    // Reference behaviour: one call per accepted instruction, in program order.
    task automatic model(input int op, input int fn, input int d1, input int d2, input longint pc);
        exp_t e;
        int r, s, a, lo, hi;
        bit fault;
        r = 0; fault = 1'b0;
        e.result = 0; e.chk_result = 1'b0; e.branch = 1'b0; e.pc_new = 0; e.fault = 1'b0;
        case (op)
            1: begin
                case (fn)
                    0: begin s = d1 + d2; r = s % 65536; mc = (s > 65535); end
                    1: begin r = (d1 - d2 + 65536) % 65536; mc = (d1 < d2); end
                    2: r = d1 & d2;
                    3: r = d1 | d2;
                    4: r = 65535 - d1;
                    5: begin s = d1 + 1; r = s % 65536; mc = (s > 65535); end
                    6: begin r = (d1 + 65535) % 65536; mc = (d1 == 0); end
                    default: r = d1;
                endcase
                mz = (r == 0); mn = (r >= 32768);
                e.result = r; e.chk_result = 1'b1;
            end
            2: begin e.result = d2; e.chk_result = 1'b1; end
            3: begin a = d2 % MEM_N; push_acc(a, 0, 0); e.result = ref_mem[a]; e.chk_result = 1'b1; end
            4: begin a = d2 % MEM_N; push_acc(a, 1, d1); ref_mem[a] = d1; end
            5: if (GUARD && m_sp == 0) fault = 1'b1;
               else begin push_acc(m_sp, 1, d1); ref_mem[m_sp] = d1; m_sp = (m_sp + MEM_N - 1) % MEM_N; end
            6: if (GUARD && m_sp + 1 > SP_TOP) fault = 1'b1;
               else begin
                   a = (m_sp + 1) % MEM_N; push_acc(a, 0, 0);
                   e.result = ref_mem[a]; e.chk_result = 1'b1; m_sp = a;
               end
            7: if (GUARD && m_sp < 2) fault = 1'b1;
               else begin
                   hi = int'(pc / 65536); lo = int'(pc % 65536);
                   push_acc(m_sp, 1, hi); ref_mem[m_sp] = hi;
                   a = (m_sp + MEM_N - 1) % MEM_N;
                   push_acc(a, 1, lo); ref_mem[a] = lo;
                   m_sp = (m_sp + MEM_N - 2) % MEM_N;
                   e.branch = 1'b1; e.pc_new = d1;
               end
            8: if (GUARD && m_sp + 2 > SP_TOP) fault = 1'b1;
               else begin
                   a = (m_sp + 1) % MEM_N; push_acc(a, 0, 0); lo = ref_mem[a];
                   a = (m_sp + 2) % MEM_N; push_acc(a, 0, 0); hi = ref_mem[a];
                   m_sp = a;
                   e.branch = 1'b1; e.pc_new = longint'(hi) * 65536 + lo;
               end
            9:  if (mz) begin e.branch = 1'b1; e.pc_new = d1; end
            10: if (mn) begin e.branch = 1'b1; e.pc_new = d1; end
            11: if (mc) begin e.branch = 1'b1; e.pc_new = d1; end
            12: begin e.branch = 1'b1; e.pc_new = d1; end
            13: mc = 1'b1;
            14: mc = 1'b0;
            default: ;
        endcase
        if (fault) begin e.fault = 1'b1; e.result = 0; e.chk_result = 1'b1; end
        e.flags = int'({mz, mn, mc});
        e.sp = m_sp;
        exp_q.push_back(e);
    endtask

    task automatic issue(input int op, input int fn, input int d1, input int d2, input longint pc);
        int n;
        n = 0;
        while (o_busy && n <= 100) begin
            v_valid = 1'($urandom); v_op = 4'($urandom); v_fn = 3'($urandom);
            v_d1 = DW'($urandom); v_d2 = DW'($urandom); v_pc = $urandom;
            @(posedge clk); #1;
            n++;
        end
        if (n > 100) begin
            check("busy_timeout", 1, 0);
            v_valid = 1'b0;
            return;
        end
        v_valid = 1'b1; v_op = op[3:0]; v_fn = fn[2:0];
        v_d1 = d1[DW-1:0]; v_d2 = d2[DW-1:0]; v_pc = pc[31:0];
        model(op, fn, d1, d2, pc);
        @(posedge clk); #1;
        v_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("drain_timeout", 1, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid) begin
                if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    if (e.chk_result) check("result", o_result, e.result);
                    check("branch", o_branch_decision, e.branch);
                    if (e.branch) check("pc_new", o_pc_new, e.pc_new);
                    check("flags", o_flags, e.flags);
                    check("sp", o_sp, e.sp);
                    check("fault", o_fault, e.fault);
                end
            end else begin
                check("idle_branch_fault", {o_branch_decision, o_fault}, 0);
            end
        end
    end

    initial begin : responder
        bit pending, acked;
        int wcnt;
        acc_t cap, ex;
        pending = 1'b0; acked = 1'b0; wcnt = 0;
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            if (acked || rst) pending = 1'b0;
            acked = 1'b0;
            if (resp_en && !rst && mem_if.o_mem_req) begin
                check("busy_with_req", o_busy, 1);
                if (!pending) begin
                    cap.addr = mem_if.o_mem_addr; cap.we = mem_if.o_mem_we; cap.wdata = mem_if.o_mem_wdata;
                    pending = 1'b1;
                    wcnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
                    if (acc_q.size() == 0) check("unexpected_access", 1, 0);
                    else begin
                        ex = acc_q.pop_front();
                        check("mem_addr", cap.addr, ex.addr);
                        check("mem_we", cap.we, ex.we);
                        if (ex.we) check("mem_wdata", cap.wdata, ex.wdata);
                    end
                end else begin
                    check("req_stable", {mem_if.o_mem_addr, mem_if.o_mem_we, mem_if.o_mem_wdata},
                          {cap.addr, cap.we, cap.wdata});
                end
                if (wcnt == 0) begin
                    resp_ack = 1'b1; acked = 1'b1;
                    if (cap.we) bus_mem[cap.addr] = int'(cap.wdata);
                    else resp_rdata = DW'(bus_mem[cap.addr]);
                end else wcnt--;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int op, d1;
        for (int i = 0; i < MEM_N; i++) begin ref_mem[i] = 0; bus_mem[i] = 0; end
        m_sp = SP_TOP; mz = 0; mn = 0; mc = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_req", mem_if.o_mem_req, 0);
        check("rst_valid", o_valid, 0);
        check("rst_result", o_result, 0);
        check("rst_branch", o_branch_decision, 0);
        check("rst_pc_new", o_pc_new, 0);
        check("rst_flags", o_flags, 0);
        check("rst_sp", o_sp, SP_TOP);
        check("rst_fault", o_fault, 0);
        rst = 1'b0;

        issue(1, 0, 'hFFFF, 'h0001, 0);
        check("alu_wrap_result", o_result, 'h0000);
        check("alu_wrap_flags", o_flags, 3'b101);
        check("alu_wrap_valid", o_valid, 1);

        fixed_delay = 2;
        issue(5, 0, 'h1234, 0, 0);
        issue(6, 0, 0, 0, 0);
        drain();
        check("push_mem_word", bus_mem[SP_TOP], 'h1234);
        check("pop_result", o_result, 'h1234);
        check("pop_sp", o_sp, SP_TOP);

        issue(7, 0, 'h0200, 0, 'h0001_0040);
        drain();
        check("call_hi_word", bus_mem[SP_TOP], 'h0001);
        check("call_lo_word", bus_mem[SP_TOP-1], 'h0040);
        check("call_sp", o_sp, SP_TOP - 2);
        issue(8, 0, 0, 0, 0);
        drain();
        check("ret_pc_new", o_pc_new, 'h0001_0040);
        check("ret_sp", o_sp, SP_TOP);
        fixed_delay = -1;

        issue(13, 0, 0, 0, 0);
        issue(11, 0, 'h0055, 0, 0);
        check("jc_taken", o_branch_decision, 1);
        check("jc_target", o_pc_new, 'h0000_0055);
        issue(14, 0, 0, 0, 0);
        issue(11, 0, 'h0077, 0, 0);
        check("jc_not_taken", o_branch_decision, 0);
        check("jc_not_taken_valid", o_valid, 1);
        drain();

        resp_en = 1'b0;
        v_valid = 1'b1; v_op = 4'd7; v_d1 = 16'h0300; v_pc = 32'h0002_0010;
        @(posedge clk); #1;
        v_valid = 1'b0;
        check("call_acc0_req", mem_if.o_mem_req, 1);
        man_ack = 1'b1;
        @(posedge clk); #1;
        man_ack = 1'b0;
        check("call_acc1_req", mem_if.o_mem_req, 1);
        check("call_acc1_addr", mem_if.o_mem_addr, SP_TOP - 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_req", mem_if.o_mem_req, 0);
        check("abort_sp", o_sp, SP_TOP);
        check("abort_valid", o_valid, 0);
        rst = 1'b0;
        m_sp = SP_TOP; mz = 0; mn = 0; mc = 0;
        resp_en = 1'b1;
        @(posedge clk); #1;
        check("abort_no_valid", o_valid, 0);

        issue(6, 0, 0, 0, 0);
        check("pop_edge_req", mem_if.o_mem_req, GUARD ? 0 : 1);
        check("pop_edge_fault", o_fault, GUARD ? 1 : 0);
        drain();
        check("pop_edge_sp", o_sp, GUARD ? SP_TOP : 0);

        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: d1 = 'hFFFF;
                1: d1 = 0;
                2: d1 = 'h8000;
                default: d1 = int'($urandom_range(0, 65535));
            endcase
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            issue(op, int'($urandom_range(0, 7)), d1, int'($urandom_range(0, 65535)), longint'($urandom));
        end
        drain();
        check("queues_empty", exp_q.size() + acc_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
